instruction_sequencer: RTL and testbench
========================================

Name: instruction_sequencer

Overview:
Holds the instruction register and the microcode step counter that feed the combinational instruction decoder. It consumes the decoder's advance, halt and instruction-register-load controls. It produces the opcode nibble, the step index and the immediate/address operand for the bus. All control state for the fetch/execute cycle lives here.

Parameters:
BUS_WIDTH, 8, width of the shared data bus and of the instruction register
INSTRUCTION_WIDTH, 4, opcode width; the opcode is taken from the upper bits of the instruction register
INSTRUCTION_STEPS, 8, number of microcode steps per instruction; STEP_WIDTH = $clog2(INSTRUCTION_STEPS)

Ports:
i_clk  in  1  system clock, all state updates on rising edge
i_reset  in  1  synchronous, active-high reset
i_bus  in  BUS_WIDTH  shared bus value, captured into the instruction register
i_instrregi  in  1  instruction register load (decoder II)
i_adv  in  1  end current instruction, return step to 0 (decoder ADV)
i_halt  in  1  halt request (decoder HLT)
o_instruction  out  INSTRUCTION_WIDTH  opcode = IR[BUS_WIDTH-1 -: INSTRUCTION_WIDTH]
o_step  out  STEP_WIDTH  current microcode step
o_operand  out  BUS_WIDTH  {zeros, IR[BUS_WIDTH-INSTRUCTION_WIDTH-1:0]}, driven onto the bus when decoder IO is asserted
o_halted  out  1  sticky halt status
o_step_wrap  out  1  sticky flag: step counter wrapped without an ADV

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (i_clk, i_reset).
- Reset values: IR=0, step=0, o_halted=0, o_step_wrap=0. o_instruction, o_step and o_operand are therefore 0. Reset overrides every other input in the same cycle. Reset mid-instruction returns to step 0 (fetch) on the next edge.
- Update enable: upd = !o_halted (further gated by the strobe when the optional feature is compiled in).
- IR: on an edge with upd && i_instrregi, IR <= i_bus. Otherwise IR holds. Outputs are registered-direct (zero combinational path from i_bus).
- Step counter, on an edge with upd, in priority order:
  - i_halt → step holds.
  - i_adv → step <= 0.
  - step == INSTRUCTION_STEPS-1 → step <= 0 and o_step_wrap <= 1.
  - else → step <= step+1.
- Halt: upd && i_halt sets o_halted <= 1 on that edge. The flag is sticky until reset. While halted, IR and step are frozen and all i_* controls are ignored.
- Simultaneous events:
  - i_instrregi together with i_adv: both apply (IR loads, step -> 0).
  - i_halt together with i_instrregi: IR loads, then freezes.
  - i_halt together with i_adv: halt wins; step holds.
- Latency: control inputs take effect on the next edge. The decoder sees the new step/opcode one cycle after its control was asserted.
- Non-power-of-2 INSTRUCTION_STEPS: wrap uses the explicit comparison above, never natural overflow.

Optional Feature:
SEQUENCER_SINGLE_STEP_EN.
- Defined:
  - Adds input i_step_req (1) and output o_step_strobe (1).
  - i_step_req is registered, and rising-edge detected against its previous registered value.
  - o_step_strobe = 1 for exactly one i_clk cycle per rising edge.
  - upd = !o_halted && o_step_strobe. IR load, step advance, halt and wrap update only on strobe cycles.
  - o_step_strobe is exported as the clock enable for the PC and other registers.
  - The strobe-detect registers reset to 0.
- Undefined: neither port exists; upd = !o_halted every cycle.

Test Plan:
- Reset then free-run with i_adv=0 for 9 cycles → o_step sequence 0,1,...,7,0; o_step_wrap=1 after the 8th edge.
- Step 1 with i_instrregi=1, i_bus=8'h1E → next cycle o_instruction=4'h1, o_operand=8'h0E, o_step=2; then i_adv at step 4 → o_step=0 next edge.
- i_halt=1 at step 2 → o_halted=1; over 10 further cycles with i_adv/i_instrregi toggling, o_step stays 2 and IR is unchanged. i_reset=1 for one cycle → all outputs 0.
- Same-cycle i_instrregi=1 (i_bus=8'hE0) and i_adv=1 → IR=8'hE0 and o_step=0 on one edge. Same-cycle i_halt and i_adv → o_step unchanged, o_halted=1.
- i_reset asserted at step 5 together with i_instrregi (i_bus=8'hFF) → IR=0, step=0, flags cleared, with no load.
- SEQUENCER_SINGLE_STEP_EN: hold i_step_req high for 5 cycles → exactly one o_step_strobe pulse and o_step increments by 1. No i_step_req edges for 20 cycles → no change. Three separate 0→1 edges → o_step advances 0→3.

Source files
------------

// File: rtl/instruction_sequencer.sv
// ----------------------------------------------------------------------------
// instruction_sequencer
//
// Holds the instruction register (IR) and the microcode step counter that
// feed the combinational instruction decoder. The decoder's II, ADV and HLT
// controls come back in here and take effect on the next rising edge.
//
// Optional feature macro: SEQUENCER_SINGLE_STEP_EN
//   When defined, state only updates on a one-cycle strobe generated from
//   a rising edge of i_step_req. The strobe is also exported so that the PC
//   and other registers can use it as their clock enable.
//
// Ports:
//   i_clk          system clock, all state updates on rising edge
//   i_reset        synchronous, active-high reset
//   i_bus          shared bus value, captured into the IR
//   i_instrregi    IR load (decoder II)
//   i_adv          end current instruction, step returns to 0 (decoder ADV)
//   i_halt         halt request (decoder HLT)
//   i_step_req     single-step request (feature builds only)
//   o_instruction  opcode, upper INSTRUCTION_WIDTH bits of the IR
//   o_step         current microcode step
//   o_operand      zero-extended lower IR bits (immediate / address)
//   o_halted       sticky halt status
//   o_step_wrap    sticky flag: step counter wrapped without an ADV
//   o_step_strobe  single-step clock enable (feature builds only)
// ----------------------------------------------------------------------------
module instruction_sequencer #(
    parameter int BUS_WIDTH         = 8,
    parameter int INSTRUCTION_WIDTH = 4,
    parameter int INSTRUCTION_STEPS = 8,
    localparam int STEP_WIDTH = (INSTRUCTION_STEPS > 1) ? $clog2(INSTRUCTION_STEPS) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [BUS_WIDTH-1:0]         i_bus,
    input  logic                         i_instrregi,
    input  logic                         i_adv,
    input  logic                         i_halt,
`ifdef SEQUENCER_SINGLE_STEP_EN
    input  logic                         i_step_req,
    output logic                         o_step_strobe,
`endif
    output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
    output logic [STEP_WIDTH-1:0]        o_step,
    output logic [BUS_WIDTH-1:0]         o_operand,
    output logic                         o_halted,
    output logic                         o_step_wrap
);

    localparam int OPERAND_BITS = BUS_WIDTH - INSTRUCTION_WIDTH;
    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

    logic [BUS_WIDTH-1:0]  ir;
    logic [STEP_WIDTH-1:0] step;
    logic                  upd;
    logic [STEP_WIDTH-1:0] step_next;
    logic                  wrap_now;

`ifdef SEQUENCER_SINGLE_STEP_EN
    logic step_req_q;
    logic step_req_prev;

    // The request is registered first, then compared with its previous
    // registered value so a held request yields exactly one strobe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            step_req_q    <= 1'b0;
            step_req_prev <= 1'b0;
        end else begin
            step_req_q    <= i_step_req;
            step_req_prev <= step_req_q;
        end
    end

    assign o_step_strobe = step_req_q & ~step_req_prev;
    assign upd           = ~o_halted & o_step_strobe;
`else
    assign upd = ~o_halted;
`endif

    // Step priority: halt holds, ADV returns to fetch, then the explicit
    // last-step compare wraps (never relies on natural overflow, so
    // non-power-of-two step counts behave).
    always_comb begin
        step_next = step;
        wrap_now  = 1'b0;
        if (i_halt) begin
            step_next = step;
        end else if (i_adv) begin
            step_next = '0;
        end else if (step == LAST_STEP) begin
            step_next = '0;
            wrap_now  = 1'b1;
        end else begin
            step_next = step + STEP_WIDTH'(1);
        end
    end

    // All sequencer state. Once halted, upd is low and everything freezes
    // until reset; an IR load in the halting cycle still lands.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ir          <= '0;
            step        <= '0;
            o_halted    <= 1'b0;
            o_step_wrap <= 1'b0;
        end else if (upd) begin
            if (i_instrregi) begin
                ir <= i_bus;
            end
            if (i_halt) begin
                o_halted <= 1'b1;
            end
            if (wrap_now) begin
                o_step_wrap <= 1'b1;
            end
            step <= step_next;
        end
    end

    assign o_instruction = ir[BUS_WIDTH-1 -: INSTRUCTION_WIDTH];
    assign o_step        = step;
    assign o_operand     = {{INSTRUCTION_WIDTH{1'b0}}, ir[OPERAND_BITS-1:0]};

endmodule

// File: tb/tb_instruction_sequencer.sv
// ----------------------------------------------------------------------------
// tb_instruction_sequencer
//
// Directed vectors with hand-computed expected outputs. Each stimulus cycle
// pushes the outputs expected after the coming edge into a scoreboard queue;
// an independent monitor pops and compares one entry after every edge.
// ----------------------------------------------------------------------------
module tb_instruction_sequencer;

    typedef struct {
        logic [3:0] instr;
        logic [2:0] step;
        logic [7:0] operand;
        logic       halted;
        logic       wrap;
        logic       strobe;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] bus = '0;
    logic       instrregi = 1'b0;
    logic       adv = 1'b0;
    logic       halt = 1'b0;
    logic [3:0] instruction;
    logic [2:0] step;
    logic [7:0] operand;
    logic       halted;
    logic       step_wrap;
`ifdef SEQUENCER_SINGLE_STEP_EN
    logic       step_req = 1'b0;
    logic       step_strobe;
`endif

    exp_t exp_q[$];
    int   num_checks = 0;
    int   num_fail   = 0;

    always #5 clk = ~clk;

    instruction_sequencer #(
        .BUS_WIDTH(8),
        .INSTRUCTION_WIDTH(4),
        .INSTRUCTION_STEPS(8)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_bus(bus),
        .i_instrregi(instrregi),
        .i_adv(adv),
        .i_halt(halt),
`ifdef SEQUENCER_SINGLE_STEP_EN
        .i_step_req(step_req),
        .o_step_strobe(step_strobe),
`endif
        .o_instruction(instruction),
        .o_step(step),
        .o_operand(operand),
        .o_halted(halted),
        .o_step_wrap(step_wrap)
    );

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic applyStimulus(input logic rst, input logic ii, input logic ad,
                                 input logic hl, input logic [7:0] b, input logic req,
                                 input logic [3:0] e_instr, input logic [2:0] e_step,
                                 input logic [7:0] e_op, input logic e_halt,
                                 input logic e_wrap, input logic e_strobe,
                                 input string name);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        instrregi = ii;
        adv       = ad;
        halt      = hl;
        bus       = b;
`ifdef SEQUENCER_SINGLE_STEP_EN
        step_req  = req;
`else
        if (req) $display("[TB] note: step request ignored in this build");
`endif
        e.instr   = e_instr;
        e.step    = e_step;
        e.operand = e_op;
        e.halted  = e_halt;
        e.wrap    = e_wrap;
        e.strobe  = e_strobe;
        e.name    = name;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [17:0] act;
        logic [17:0] req;
        act = {instruction, step, operand, halted, step_wrap, 1'b0};
        req = {e.instr, e.step, e.operand, e.halted, e.wrap, 1'b0};
`ifdef SEQUENCER_SINGLE_STEP_EN
        act[0] = step_strobe;
        req[0] = e.strobe;
`endif
        num_checks++;
        if (act !== req) begin
            num_fail++;
            $display("[TB] FAIL %s: got instr=%h step=%0d op=%h halted=%b wrap=%b strobe=%b, want instr=%h step=%0d op=%h halted=%b wrap=%b strobe=%b",
                     e.name, act[17:14], act[13:11], act[10:3], act[2], act[1], act[0],
                     e.instr, e.step, e.operand, e.halted, e.wrap, e.strobe);
        end
    endtask

    // Monitor: one scoreboard entry per edge, sampled just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        int wait_cycles;
`ifdef SEQUENCER_SINGLE_STEP_EN
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 4'h0, 3'd0, 8'h00, 0, 0, 0, "reset");
        // Held request: one strobe, one increment.
        applyStimulus(0, 0, 0, 0, 8'h00, 1, 4'h0, 3'd0, 8'h00, 0, 0, 1, "held_req_strobe");
        for (int k = 0; k < 4; k++)
            applyStimulus(0, 0, 0, 0, 8'h00, 1, 4'h0, 3'd1, 8'h00, 0, 0, 0, "held_req_once");
        for (int k = 0; k < 20; k++)
            applyStimulus(0, 0, 0, 0, 8'h00, 0, 4'h0, 3'd1, 8'h00, 0, 0, 0, "no_req_idle");
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 4'h0, 3'd0, 8'h00, 0, 0, 0, "reset2");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 8'h00, 1, 4'h0, 3'(k), 8'h00, 0, 0, 1, "edge_strobe");
            applyStimulus(0, 0, 0, 0, 8'h00, 0, 4'h0, 3'(k + 1), 8'h00, 0, 0, 0, "edge_advance");
        end
`else
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 4'h0, 3'd0, 8'h00, 0, 0, 0, "reset");
        // Free run: 1..7 then wrap to 0 with the sticky flag set.
        for (int k = 1; k <= 8; k++)
            applyStimulus(0, 0, 0, 0, 8'h00, 0, 4'h0, 3'(k % 8), 8'h00, 0, (k == 8), 0, "freerun");
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 4'h0, 3'd1, 8'h00, 0, 1, 0, "wrap_sticky");
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 4'h0, 3'd0, 8'h00, 0, 0, 0, "reset_clear_wrap");
        // IR load at step 1, ADV at step 4.
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 4'h0, 3'd1, 8'h00, 0, 0, 0, "to_step1");
        applyStimulus(0, 1, 0, 0, 8'h1E, 0, 4'h1, 3'd2, 8'h0E, 0, 0, 0, "ir_load_1e");
        applyStimulus(0, 0, 0, 0, 8'h55, 0, 4'h1, 3'd3, 8'h0E, 0, 0, 0, "ir_hold");
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 4'h1, 3'd4, 8'h0E, 0, 0, 0, "to_step4");
        applyStimulus(0, 0, 1, 0, 8'h00, 0, 4'h1, 3'd0, 8'h0E, 0, 0, 0, "adv_step0");
        // Halt at step 2, then everything frozen.
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 4'h1, 3'd1, 8'h0E, 0, 0, 0, "to_step1b");
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 4'h1, 3'd2, 8'h0E, 0, 0, 0, "to_step2");
        applyStimulus(0, 0, 0, 1, 8'h00, 0, 4'h1, 3'd2, 8'h0E, 1, 0, 0, "halt_set");
        for (int k = 0; k < 10; k++)
            applyStimulus(0, k[0], ~k[0], 0, 8'hA5, 0, 4'h1, 3'd2, 8'h0E, 1, 0, 0, "halt_frozen");
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 4'h0, 3'd0, 8'h00, 0, 0, 0, "reset_unhalt");
        // Same-cycle II + ADV, then HLT + ADV.
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 4'h0, 3'd1, 8'h00, 0, 0, 0, "to_step1c");
        applyStimulus(0, 1, 1, 0, 8'hE0, 0, 4'hE, 3'd0, 8'h00, 0, 0, 0, "ii_and_adv");
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 4'hE, 3'd1, 8'h00, 0, 0, 0, "after_ii_adv");
        applyStimulus(0, 0, 1, 1, 8'h00, 0, 4'hE, 3'd1, 8'h00, 1, 0, 0, "halt_beats_adv");
        // Same-cycle HLT + II: load lands, then frozen.
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 4'h0, 3'd0, 8'h00, 0, 0, 0, "reset3");
        applyStimulus(0, 1, 0, 1, 8'h3C, 0, 4'h3, 3'd0, 8'h0C, 1, 0, 0, "halt_with_load");
        applyStimulus(0, 1, 0, 0, 8'h77, 0, 4'h3, 3'd0, 8'h0C, 1, 0, 0, "load_after_halt");
        // Reset at step 5 beats a simultaneous IR load.
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 4'h0, 3'd0, 8'h00, 0, 0, 0, "reset4");
        for (int k = 1; k <= 5; k++)
            applyStimulus(0, 0, 0, 0, 8'h00, 0, 4'h0, 3'(k), 8'h00, 0, 0, 0, "to_step5");
        applyStimulus(1, 1, 0, 0, 8'hFF, 0, 4'h0, 3'd0, 8'h00, 0, 0, 0, "reset_beats_load");
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 4'h0, 3'd1, 8'h00, 0, 0, 0, "no_load_after_reset");
        // ADV on the last step: back to 0 without a wrap flag.
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 4'h0, 3'd0, 8'h00, 0, 0, 0, "reset5");
        for (int k = 1; k <= 7; k++)
            applyStimulus(0, 0, 0, 0, 8'h00, 0, 4'h0, 3'(k), 8'h00, 0, 0, 0, "to_step7");
        applyStimulus(0, 0, 1, 0, 8'h00, 0, 4'h0, 3'd0, 8'h00, 0, 0, 0, "adv_at_last_no_wrap");
`endif
        @(negedge clk);
        reset = 1'b0;
        instrregi = 1'b0;
        adv = 1'b0;
        halt = 1'b0;
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            num_checks++;
            num_fail++;
            $display("[TB] FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
